// File: rtl/xmem_param_pkg.sv
// Shared xmem parameters and types for the pipelined bank router.
// Bank counts follow the legacy per-type table; BIW covers the widest bank array.
package xmem_param_pkg;

    localparam int XMEM_AW            = 16;
    localparam int MAX_PARTITION      = 4;
    localparam int LOG2_MAX_PARTITION = $clog2(MAX_PARTITION);

    localparam int MEM_TYPE_SCALAR = 0;
    localparam int MEM_TYPE_ARRAY  = 1;
    localparam int MEM_TYPE_CYCLIC = 2;

    localparam int BANK_NUM [3] = '{4, 8, 8};

    localparam int NB_MAX = (BANK_NUM[MEM_TYPE_SCALAR] > BANK_NUM[MEM_TYPE_ARRAY]) ?
                            ((BANK_NUM[MEM_TYPE_SCALAR] > BANK_NUM[MEM_TYPE_CYCLIC]) ?
                             BANK_NUM[MEM_TYPE_SCALAR] : BANK_NUM[MEM_TYPE_CYCLIC]) :
                            ((BANK_NUM[MEM_TYPE_ARRAY] > BANK_NUM[MEM_TYPE_CYCLIC]) ?
                             BANK_NUM[MEM_TYPE_ARRAY] : BANK_NUM[MEM_TYPE_CYCLIC]);
    localparam int BIW = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;

    typedef enum logic [1:0] {
        MEM_SCALAR = 2'd0,
        MEM_ARRAY  = 2'd1,
        MEM_CYCLIC = 2'd2,
        MEM_NONE   = 2'd3
    } mem_type_e;

    typedef enum logic [2:0] {
        CFG_ARR_START = 3'd0,
        CFG_CYC_START = 3'd1,
        CFG_ARR_SIZE  = 3'd2,
        CFG_CYC_SIZE  = 3'd3,
        CFG_LIMIT     = 3'd4
    } cfg_field_e;

    typedef struct packed {
        mem_type_e            mtype;
        logic [BIW-1:0]       bank;
        logic [XMEM_AW-1:0]   offset;
        logic                 err;
    } xmem_route_rsp_t;

endpackage

// File: rtl/xmem_bank_route_ch.sv
// One request channel: S1 classifies the address against its partition,
// S2 computes bank/offset/error and holds the response until consumed.
module xmem_bank_route_ch #(
    parameter int AW        = xmem_param_pkg::XMEM_AW,
    parameter int NUM_PART  = xmem_param_pkg::MAX_PARTITION,
    parameter int NB_SCALAR = xmem_param_pkg::BANK_NUM[xmem_param_pkg::MEM_TYPE_SCALAR],
    parameter int NB_ARRAY  = xmem_param_pkg::BANK_NUM[xmem_param_pkg::MEM_TYPE_ARRAY],
    parameter int NB_CYCLIC = xmem_param_pkg::BANK_NUM[xmem_param_pkg::MEM_TYPE_CYCLIC],
    parameter int BIW       = xmem_param_pkg::BIW,
    localparam int PW       = $clog2(NUM_PART),
    localparam int SHW      = $clog2(AW)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_PART-1:0][AW-1:0]   arr_start,
    input  logic [NUM_PART-1:0][AW-1:0]   cyc_start,
    input  logic [NUM_PART-1:0][AW-1:0]   limit,
    input  logic [NUM_PART-1:0][SHW-1:0]  arr_shift,
    input  logic [NUM_PART-1:0][SHW-1:0]  cyc_shift,
    input  logic [NUM_PART-1:0]           arr_shift_ok,
    input  logic [NUM_PART-1:0]           cyc_shift_ok,
    input  logic                          cfg_hold,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [AW-1:0]                 req_adr,
    input  logic [PW-1:0]                 req_part,
    input  logic                          req_risc,
    output logic                          busy,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [1:0]                    rsp_type,
    output logic [BIW-1:0]                rsp_bank,
    output logic [AW-1:0]                 rsp_offset,
    output logic                          rsp_err
);
    import xmem_param_pkg::*;

    localparam int SBW = $clog2(NB_SCALAR);
    localparam logic [AW-1:0] ONES = '1;

    if ((NB_SCALAR & (NB_SCALAR - 1)) != 0) begin : g_bad_nb_scalar
        $error("NB_SCALAR must be a power of two");
    end
    if (NB_ARRAY > (1 << BIW) || NB_CYCLIC > (1 << BIW) || NB_SCALAR > (1 << BIW)) begin : g_bad_biw
        $error("BIW too narrow for the bank counts");
    end

    // Valid/ready: a transfer happens on a clock edge where valid and ready are both
    // high; a stalled producer keeps valid and payload stable until that edge.
    logic s1_valid, s2_valid, s1_adv, s2_adv, fire;

    mem_type_e      s1_type;
    logic [AW-1:0]  s1_adr, s1_base, s1_limit;
    logic [SHW-1:0] s1_shift;
    logic           s1_ok;

    mem_type_e      s2_type;
    logic [BIW-1:0] s2_bank;
    logic [AW-1:0]  s2_off;
    logic           s2_err;

    mem_type_e      c_type;
    logic [AW-1:0]  c_base;
    logic [SHW-1:0] c_shift;
    logic           c_ok;

    logic [AW-1:0]  diff, bank_full, word, nb, d_off;
    logic [BIW-1:0] d_bank_raw, d_bank;
    logic           lim_err, d_err;

    assign s2_adv    = !s2_valid || rsp_ready;
    assign s1_adv    = s2_adv || !s1_valid;
    assign req_ready = s1_adv && !cfg_hold;
    assign fire      = req_valid && req_ready;
    assign busy      = s1_valid || s2_valid;

    always_comb begin
        c_type  = MEM_CYCLIC;
        c_base  = cyc_start[req_part];
        c_shift = cyc_shift[req_part];
        c_ok    = cyc_shift_ok[req_part];
        if (req_risc) begin
            c_type = MEM_NONE;
        end else if (req_adr < arr_start[req_part]) begin
            c_type = MEM_SCALAR;
        end else if (req_adr < cyc_start[req_part]) begin
            c_type  = MEM_ARRAY;
            c_base  = arr_start[req_part];
            c_shift = arr_shift[req_part];
            c_ok    = arr_shift_ok[req_part];
        end
    end

    // Range check runs on the full-width bank index; truncation to BIW comes after.
    always_comb begin
        diff       = s1_adr - s1_base;
        bank_full  = diff >> s1_shift;
        word       = s1_adr >> 2;
        lim_err    = (s1_limit != '0) && (s1_adr >= s1_limit);
        nb         = AW'(NB_CYCLIC);
        d_bank_raw = '0;
        d_off      = '0;
        d_err      = 1'b0;
        case (s1_type)
            MEM_SCALAR: begin
                d_bank_raw = BIW'(word & AW'(NB_SCALAR - 1));
                d_off      = (word >> SBW) << 2;
                d_err      = lim_err;
            end
            MEM_ARRAY, MEM_CYCLIC: begin
                nb         = (s1_type == MEM_ARRAY) ? AW'(NB_ARRAY) : AW'(NB_CYCLIC);
                d_bank_raw = BIW'(bank_full);
                d_off      = diff & ~(ONES << s1_shift);
                d_err      = !s1_ok || (bank_full >= nb) || lim_err;
            end
            default: ;
        endcase
        d_bank = d_err ? '0 : d_bank_raw;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_type  <= MEM_SCALAR;
            s1_adr   <= '0;
            s1_base  <= '0;
            s1_limit <= '0;
            s1_shift <= '0;
            s1_ok    <= 1'b0;
            s2_valid <= 1'b0;
            s2_type  <= MEM_SCALAR;
            s2_bank  <= '0;
            s2_off   <= '0;
            s2_err   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= fire;
                if (fire) begin
                    s1_type  <= c_type;
                    s1_adr   <= req_adr;
                    s1_base  <= c_base;
                    s1_limit <= limit[req_part];
                    s1_shift <= c_shift;
                    s1_ok    <= c_ok;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_type <= s1_type;
                    s2_bank <= d_bank;
                    s2_off  <= d_off;
                    s2_err  <= d_err;
                end
            end
        end
    end

    assign rsp_valid  = s2_valid;
    assign rsp_type   = s2_type;
    assign rsp_bank   = s2_bank;
    assign rsp_offset = s2_off;
    assign rsp_err    = s2_err;

endmodule

// File: rtl/xmem_bank_router.sv
// Multi-channel xmem bank router: shared partition config registers plus one
// two-stage decode pipeline per request channel.
module xmem_bank_router #(
    parameter int NUM_CH    = 2,
    parameter int AW        = xmem_param_pkg::XMEM_AW,
    parameter int NUM_PART  = xmem_param_pkg::MAX_PARTITION,
    parameter int NB_SCALAR = xmem_param_pkg::BANK_NUM[xmem_param_pkg::MEM_TYPE_SCALAR],
    parameter int NB_ARRAY  = xmem_param_pkg::BANK_NUM[xmem_param_pkg::MEM_TYPE_ARRAY],
    parameter int NB_CYCLIC = xmem_param_pkg::BANK_NUM[xmem_param_pkg::MEM_TYPE_CYCLIC],
    parameter int BIW       = xmem_param_pkg::BIW,
    localparam int PW       = $clog2(NUM_PART)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         cfg_we,
    input  logic [PW-1:0]                cfg_part,
    input  logic [2:0]                   cfg_field,
    input  logic [AW-1:0]                cfg_data,
    output logic                         cfg_ready,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0][AW-1:0]    req_adr,
    input  logic [NUM_CH-1:0][PW-1:0]    req_part,
    input  logic [NUM_CH-1:0]            req_risc,
    output logic [NUM_CH-1:0]            rsp_valid,
    input  logic [NUM_CH-1:0]            rsp_ready,
    output logic [NUM_CH-1:0][1:0]       rsp_type,
    output logic [NUM_CH-1:0][BIW-1:0]   rsp_bank,
    output logic [NUM_CH-1:0][AW-1:0]    rsp_offset,
    output logic [NUM_CH-1:0]            rsp_err
);
    import xmem_param_pkg::*;

    localparam int SHW = $clog2(AW);

    logic [NUM_PART-1:0][AW-1:0]  arr_start, cyc_start, limit;
    logic [NUM_PART-1:0][SHW-1:0] arr_shift, cyc_shift;
    logic [NUM_PART-1:0]          arr_shift_ok, cyc_shift_ok;
    logic [NUM_CH-1:0]            busy;
    logic                         cfg_wr;

    function automatic logic [SHW-1:0] lowest_set(input logic [AW-1:0] v);
        logic [SHW-1:0] idx;
        idx = '0;
        for (int i = AW - 1; i >= 0; i--) begin
            if (v[i]) idx = SHW'(i);
        end
        return idx;
    endfunction

    // Config only lands with every pipeline empty, so no in-flight request ever
    // sees a half-updated partition.
    assign cfg_ready = ~|busy;
    assign cfg_wr    = cfg_we && cfg_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arr_start    <= '0;
            cyc_start    <= '0;
            limit        <= '0;
            arr_shift    <= '0;
            cyc_shift    <= '0;
            arr_shift_ok <= '0;
            cyc_shift_ok <= '0;
        end else if (cfg_wr) begin
            case (cfg_field_e'(cfg_field))
                CFG_ARR_START: arr_start[cfg_part] <= cfg_data;
                CFG_CYC_START: cyc_start[cfg_part] <= cfg_data;
                CFG_ARR_SIZE: begin
                    arr_shift[cfg_part]    <= lowest_set(cfg_data);
                    arr_shift_ok[cfg_part] <= |cfg_data;
                end
                CFG_CYC_SIZE: begin
                    cyc_shift[cfg_part]    <= lowest_set(cfg_data);
                    cyc_shift_ok[cfg_part] <= |cfg_data;
                end
                CFG_LIMIT:     limit[cfg_part] <= cfg_data;
                default: ;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        xmem_bank_route_ch #(
            .AW(AW), .NUM_PART(NUM_PART), .NB_SCALAR(NB_SCALAR),
            .NB_ARRAY(NB_ARRAY), .NB_CYCLIC(NB_CYCLIC), .BIW(BIW)
        ) u_ch (
            .clk          (clk),
            .rstn         (rstn),
            .arr_start    (arr_start),
            .cyc_start    (cyc_start),
            .limit        (limit),
            .arr_shift    (arr_shift),
            .cyc_shift    (cyc_shift),
            .arr_shift_ok (arr_shift_ok),
            .cyc_shift_ok (cyc_shift_ok),
            .cfg_hold     (cfg_wr),
            .req_valid    (req_valid[c]),
            .req_ready    (req_ready[c]),
            .req_adr      (req_adr[c]),
            .req_part     (req_part[c]),
            .req_risc     (req_risc[c]),
            .busy         (busy[c]),
            .rsp_valid    (rsp_valid[c]),
            .rsp_ready    (rsp_ready[c]),
            .rsp_type     (rsp_type[c]),
            .rsp_bank     (rsp_bank[c]),
            .rsp_offset   (rsp_offset[c]),
            .rsp_err      (rsp_err[c])
        );
    end

endmodule

// File: tb/tb_xmem_bank_router.sv
// Bench for xmem_bank_router: directed decode, backpressure, config drain,
// error and mid-operation reset scenarios, plus a randomized two-channel run.
module tb_xmem_bank_router;
    import xmem_param_pkg::*;

    localparam int NCH  = 2;
    localparam int AW   = XMEM_AW;
    localparam int PW   = LOG2_MAX_PARTITION;
    localparam int W    = $bits(xmem_route_rsp_t);
    localparam int NB_S = 4;
    localparam int NB_A = 8;
    localparam int NB_C = 8;

    logic                     clk, rstn, cfg_we, cfg_ready;
    logic [PW-1:0]            cfg_part;
    logic [2:0]               cfg_field;
    logic [AW-1:0]            cfg_data;
    logic [NCH-1:0]           req_valid, req_ready, req_risc, rsp_valid, rsp_ready, rsp_err;
    logic [NCH-1:0][AW-1:0]   req_adr, rsp_offset;
    logic [NCH-1:0][PW-1:0]   req_part;
    logic [NCH-1:0][1:0]      rsp_type;
    logic [NCH-1:0][BIW-1:0]  rsp_bank;

    xmem_bank_router dut (
        .clk(clk), .rstn(rstn),
        .cfg_we(cfg_we), .cfg_part(cfg_part), .cfg_field(cfg_field),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .req_valid(req_valid), .req_ready(req_ready), .req_adr(req_adr),
        .req_part(req_part), .req_risc(req_risc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
        .rsp_bank(rsp_bank), .rsp_offset(rsp_offset), .rsp_err(rsp_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int accepted [NCH];
    bit flag_a, flag_b;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    logic [AW-1:0] m_arr_start [4];
    logic [AW-1:0] m_cyc_start [4];
    logic [AW-1:0] m_arr_size  [4];
    logic [AW-1:0] m_cyc_size  [4];
    logic [AW-1:0] m_limit     [4];

    function automatic xmem_route_rsp_t pk(input int t, input int b, input int o, input int e);
        xmem_route_rsp_t r;
        r.mtype  = mem_type_e'(t[1:0]);
        r.bank   = b[BIW-1:0];
        r.offset = o[AW-1:0];
        r.err    = e[0];
        return r;
    endfunction

    // Reference decode written directly from the address-map rules.
    function automatic xmem_route_rsp_t model(input logic [AW-1:0] a, input int p, input logic risc);
        int t, base, size, gran, diff, bnk, nb, off, ai;
        logic lim;
        ai  = int'(a);
        lim = (m_limit[p] != 0) && (a >= m_limit[p]);
        if (risc) return pk(3, 0, 0, 0);
        if (a < m_arr_start[p]) return pk(0, lim ? 0 : (ai / 4) % NB_S, ((ai / 4) / NB_S) * 4, int'(lim));
        if (a < m_cyc_start[p]) begin
            t = 1; base = int'(m_arr_start[p]); size = int'(m_arr_size[p]); nb = NB_A;
        end else begin
            t = 2; base = int'(m_cyc_start[p]); size = int'(m_cyc_size[p]); nb = NB_C;
        end
        diff = (ai - base) & 'hFFFF;
        if (size == 0) return pk(t, 0, 0, 1);
        gran = size & (-size);
        bnk  = diff / gran;
        off  = diff % gran;
        if (bnk >= nb || lim) return pk(t, 0, off, 1);
        return pk(t, bnk, off, 0);
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 4; i++) begin
            m_arr_start[i] = '0; m_cyc_start[i] = '0; m_arr_size[i] = '0;
            m_cyc_size[i] = '0;  m_limit[i] = '0;
        end
    endtask

    task automatic model_write(input int p, input int f, input logic [AW-1:0] d);
        case (f)
            0: m_arr_start[p] = d;
            1: m_cyc_start[p] = d;
            2: m_arr_size[p]  = d;
            3: m_cyc_size[p]  = d;
            4: m_limit[p]     = d;
            default: ;
        endcase
    endtask

    // driver tasks
    task automatic cfg_write(input int p, input int f, input logic [AW-1:0] d);
        bit acc = 0;
        cfg_we = 1'b1; cfg_part = PW'(p); cfg_field = 3'(f); cfg_data = d;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (cfg_ready) begin
                acc = 1;
                model_write(p, f, d);
            end
            @(posedge clk); #1;
        end
        cfg_we = 1'b0;
        total_cnt++;
        if (!acc) $display("FAIL cfg_write_timeout part=%0d field=%0d got cfg_ready=0 expected 1", p, f);
        else pass_cnt++;
    endtask

    task automatic send(input int ch, input logic [AW-1:0] a, input int p, input logic risc,
                        input xmem_route_rsp_t exp);
        bit acc = 0;
        req_valid[ch] = 1'b1; req_adr[ch] = a; req_part[ch] = PW'(p); req_risc[ch] = risc;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (req_ready[ch]) begin
                acc = 1;
                accepted[ch]++;
                if (ch == 0) exp_q0.push_back(exp);
                else         exp_q1.push_back(exp);
            end
            @(posedge clk); #1;
        end
        req_valid[ch] = 1'b0;
        total_cnt++;
        if (!acc) $display("FAIL req_timeout ch%0d adr=%h got req_ready=0 expected 1", ch, a);
        else pass_cnt++;
    endtask

    task automatic rand_send(input int ch);
        logic [AW-1:0] a;
        int p;
        logic risc;
        a    = AW'($urandom_range(0, 'h3FF));
        p    = $urandom_range(0, 2);
        risc = ($urandom_range(0, 7) == 0);
        send(ch, a, p, risc, model(a, p, risc));
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int n = 0; n < 200 && !idle; n++) begin
            @(negedge clk);
            idle = (exp_q0.size() == 0) && (exp_q1.size() == 0) && (rsp_valid == '0);
        end
        total_cnt++;
        if (!idle) $display("FAIL drain_timeout got pending=%0d/%0d expected 0/0", exp_q0.size(), exp_q1.size());
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    // scoreboard
    always @(negedge clk) begin
        logic [W-1:0] got, exp;
        bit empty;
        for (int ch = 0; ch < NCH; ch++) begin
            if (rstn && rsp_valid[ch] && rsp_ready[ch]) begin
                got = {rsp_type[ch], rsp_bank[ch], rsp_offset[ch], rsp_err[ch]};
                exp = '0;
                if (ch == 0) begin
                    empty = (exp_q0.size() == 0);
                    if (!empty) exp = exp_q0.pop_front();
                end else begin
                    empty = (exp_q1.size() == 0);
                    if (!empty) exp = exp_q1.pop_front();
                end
                total_cnt++;
                if (empty)
                    $display("FAIL rsp_unexpected ch%0d got=%h expected no response", ch, got);
                else if (got !== exp)
                    $display("FAIL rsp_data ch%0d got=%h expected=%h", ch, got, exp);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic test_reset();
        total_cnt++;
        if (rsp_valid !== '0 || rsp_err !== '0) $display("FAIL reset_valid_err got=%b/%b expected 00/00", rsp_valid, rsp_err);
        else pass_cnt++;
        total_cnt++;
        if (rsp_type !== '0 || rsp_bank !== '0 || rsp_offset !== '0)
            $display("FAIL reset_payload got type=%h bank=%h off=%h expected 0", rsp_type, rsp_bank, rsp_offset);
        else pass_cnt++;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got=%b expected 1", cfg_ready);
        else pass_cnt++;
    endtask

    task automatic test_decode();
        rsp_ready = '1;
        cfg_write(0, 0, 'h100);
        cfg_write(0, 1, 'h300);
        cfg_write(0, 2, 'h40);
        cfg_write(0, 3, 'h20);
        send(0, 'h00C, 0, 1'b0, pk(0, 3, 0, 0));
        @(negedge clk);
        total_cnt++;
        if (rsp_valid[0] !== 1'b0) $display("FAIL latency_early got rsp_valid=%b expected 0", rsp_valid[0]);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (rsp_valid[0] !== 1'b1) $display("FAIL latency_two got rsp_valid=%b expected 1", rsp_valid[0]);
        else pass_cnt++;
        @(posedge clk); #1;
        send(0, 'h1C4, 0, 1'b0, pk(1, 3, 4, 0));
        send(0, 'h344, 0, 1'b0, pk(2, 2, 4, 0));
        send(0, 'h400, 0, 1'b0, pk(2, 0, 0, 1));
        wait_idle();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] snap;
        bit stable = 1;
        rsp_ready[0] = 1'b0;
        accepted[0]  = 0;
        flag_a       = 0;
        fork
            begin
                send(0, 'h1C4, 0, 1'b0, model('h1C4, 0, 1'b0));
                send(0, 'h344, 0, 1'b0, model('h344, 0, 1'b0));
                send(0, 'h008, 0, 1'b0, model('h008, 0, 1'b0));
                send(0, 'h2C0, 0, 1'b0, model('h2C0, 0, 1'b0));
                flag_a = 1;
            end
        join_none
        repeat (4) @(negedge clk);
        total_cnt++;
        if (accepted[0] !== 2) $display("FAIL bp_accepted got=%0d expected 2", accepted[0]);
        else pass_cnt++;
        total_cnt++;
        if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b1)
            $display("FAIL bp_flags got req_ready=%b rsp_valid=%b expected 0/1", req_ready[0], rsp_valid[0]);
        else pass_cnt++;
        snap = {rsp_type[0], rsp_bank[0], rsp_offset[0], rsp_err[0]};
        repeat (3) begin
            @(negedge clk);
            if ({rsp_type[0], rsp_bank[0], rsp_offset[0], rsp_err[0]} !== snap || rsp_valid[0] !== 1'b1) stable = 0;
        end
        total_cnt++;
        if (!stable) $display("FAIL bp_stable got changing outputs expected hold of %h", snap);
        else pass_cnt++;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
        for (int n = 0; n < 100 && !flag_a; n++) @(posedge clk);
        #1;
        wait_idle();
    endtask

    task automatic test_cfg_busy();
        bit held = 1;
        rsp_ready[0] = 1'b0;
        flag_b       = 0;
        send(0, 'h1C4, 0, 1'b0, pk(1, 3, 4, 0));
        send(0, 'h13C, 0, 1'b0, pk(1, 0, 'h3C, 0));
        fork
            begin
                cfg_write(0, 2, 'h80);
                flag_b = 1;
            end
        join_none
        repeat (3) begin
            @(negedge clk);
            if (cfg_ready !== 1'b0 || flag_b) held = 0;
        end
        total_cnt++;
        if (!held) $display("FAIL cfg_busy_hold got cfg_ready=%b expected 0 while in flight", cfg_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
        for (int n = 0; n < 100 && !flag_b; n++) @(posedge clk);
        #1;
        send(0, 'h1C4, 0, 1'b0, pk(1, 1, 'h44, 0));
        send(0, 'h17C, 0, 1'b0, pk(1, 0, 'h7C, 0));
        wait_idle();
    endtask

    task automatic test_cfg_priority();
        req_valid[1] = 1'b1; req_adr[1] = 'h25; req_part[1] = PW'(3); req_risc[1] = 1'b0;
        cfg_we = 1'b1; cfg_part = PW'(3); cfg_field = 3'd3; cfg_data = 'h10;
        @(negedge clk);
        total_cnt++;
        if (cfg_ready !== 1'b1 || req_ready[1] !== 1'b0)
            $display("FAIL cfg_priority got cfg_ready=%b req_ready=%b expected 1/0", cfg_ready, req_ready[1]);
        else pass_cnt++;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_write(3, 3, 'h10);
        send(1, 'h25, 3, 1'b0, model('h25, 3, 1'b0));
        wait_idle();
    endtask

    task automatic test_errors();
        cfg_write(0, 2, 'h0);
        send(0, 'h1C4, 0, 1'b0, pk(1, 0, 0, 1));
        send(0, 'h1C4, 0, 1'b1, pk(3, 0, 0, 0));
        send(1, 'h344, 0, 1'b1, pk(3, 0, 0, 0));
        wait_idle();
    endtask

    task automatic test_random();
        cfg_write(1, 0, 'h80);
        cfg_write(1, 1, 'h200);
        cfg_write(1, 2, 'h10);
        cfg_write(1, 3, 'h30);
        cfg_write(1, 4, 'h300);
        cfg_write(2, 0, 'h40);
        cfg_write(2, 1, 'h40);
        cfg_write(2, 3, 'h8);
        cfg_write(0, 2, 'h40);
        flag_a = 0; flag_b = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) rand_send(0);
                flag_a = 1;
            end
            begin
                for (int i = 0; i < 16; i++) rand_send(1);
                flag_b = 1;
            end
            begin
                for (int n = 0; n < 2000 && !(flag_a && flag_b); n++) begin
                    @(posedge clk); #1;
                    rsp_ready = 2'($urandom_range(0, 3));
                end
                rsp_ready = '1;
            end
        join
        wait_idle();
    endtask

    task automatic test_reset_mid();
        bit quiet = 1;
        rsp_ready = '0;
        fork
            begin
                send(0, 'h1C4, 0, 1'b0, model('h1C4, 0, 1'b0));
                send(0, 'h00C, 0, 1'b0, model('h00C, 0, 1'b0));
            end
            begin
                send(1, 'h344, 0, 1'b0, model('h344, 0, 1'b0));
                send(1, 'h2F0, 1, 1'b0, model('h2F0, 1, 1'b0));
            end
        join
        rstn = 1'b0;
        #1;
        total_cnt++;
        if (rsp_valid !== '0) $display("FAIL reset_mid_valid got=%b expected 00", rsp_valid);
        else pass_cnt++;
        exp_q0.delete();
        exp_q1.delete();
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rstn      = 1'b1;
        rsp_ready = '1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== '0) quiet = 0;
        end
        total_cnt++;
        if (!quiet) $display("FAIL reset_stale got rsp_valid activity expected none");
        else pass_cnt++;
        @(posedge clk); #1;
        send(1, 'h010, 0, 1'b1, pk(3, 0, 0, 0));
        send(0, 'h010, 0, 1'b0, pk(2, 0, 0, 1));
        wait_idle();
    endtask

    initial begin
        rstn = 1'b0; cfg_we = 1'b0; cfg_part = '0; cfg_field = '0; cfg_data = '0;
        req_valid = '0; req_adr = '0; req_part = '0; req_risc = '0; rsp_ready = '0;
        accepted[0] = 0; accepted[1] = 0;
        flag_a = 0; flag_b = 0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rstn = 1'b1;
        @(posedge clk); #1;
        test_decode();
        test_backpressure();
        test_cfg_busy();
        test_cfg_priority();
        test_errors();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xmem_bank_router.md
Name: xmem_bank_router

Overview:
- Pipelined, multi-channel successor to the combinational xmem bank decoder.
- Each of NUM_CH request channels presents a partition-relative address and partition index. The block returns memory type (scalar/array/cyclic), bank index, bank-local word offset and an out-of-range flag after a fixed 2-cycle latency.
- Partition layout is programmed through a config write port and held in internal registers. Sub-bank depth shifts are precomputed at write time.
- Sits between the RISC/HLS request arbiters and the per-type xmem bank arrays.

Parameters:
- NUM_CH, 2, number of independent request channels.
- AW, XMEM_AW, address/config width.
- NUM_PART, MAX_PARTITION, number of partitions.
- NB_SCALAR, BANK_NUM[MEM_TYPE_SCALAR], scalar bank count.
- NB_ARRAY, BANK_NUM[MEM_TYPE_ARRAY], array bank count.
- NB_CYCLIC, BANK_NUM[MEM_TYPE_CYCLIC], cyclic bank count.
- BIW, $clog2 of the largest bank count, bank index width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_part  in  LOG2_MAX_PARTITION  target partition.
- cfg_field  in  3  0=arrStart, 1=cycStart, 2=arrSize, 3=cycSize, 4=limit.
- cfg_data  in  AW  write value.
- cfg_ready  out  1  config write accepted this cycle.
- req_valid  in  [NUM_CH]  request valid.
- req_ready  out  [NUM_CH]  request accepted.
- req_adr  in  [NUM_CH][AW]  partition-relative byte address.
- req_part  in  [NUM_CH][LOG2_MAX_PARTITION]  partition index.
- req_risc  in  [NUM_CH]  RISC command bypass; no decode.
- rsp_valid  out  [NUM_CH]  result valid.
- rsp_ready  in  [NUM_CH]  result consumed.
- rsp_type  out  [NUM_CH][2]  0=scalar, 1=array, 2=cyclic, 3=none.
- rsp_bank  out  [NUM_CH][BIW]  bank index.
- rsp_offset  out  [NUM_CH][AW]  bank-local byte offset.
- rsp_err  out  [NUM_CH]  address out of range or bad config.

Behaviour:
- Reset (async, rstn=0): all config registers 0, all shift-valid bits 0. All stage valids 0. Outputs rsp_valid=0, rsp_type=0, rsp_bank=0, rsp_offset=0, rsp_err=0.
- Per-channel pipeline:
  - S1 registers the request and classification.
  - S2 registers bank and offset; S2 drives the rsp_* ports.
  - Latency is exactly 2 cycles from the req handshake to rsp_valid with no stalls. Throughput is 1 per channel per cycle.
- Flow control:
  - S2 advances when !s2_valid || rsp_ready.
  - S1 advances when S2 advances or !s1_valid.
  - req_ready = (S1 may load) && !(cfg_we && cfg_ready).
  - Outputs hold stable while rsp_valid && !rsp_ready.
- Config apply:
  - cfg_ready = all S1/S2 valids 0 across all channels (pipelines drained).
  - cfg_we && cfg_ready writes in that cycle; the value is visible to requests accepted on the next cycle.
  - A simultaneous cfg_we and req_valid gives priority to config: req_ready=0 that cycle.
  - cfg_we with cfg_ready=0 is ignored. The master holds cfg_we until cfg_ready.
- Size write (arrSize/cycSize):
  - Store the shift = index of the lowest set bit of cfg_data and set shift-valid=1.
  - cfg_data=0 sets shift-valid=0.
  - A non-power-of-two size is treated as its lowest set bit, matching the legacy divider.
- Classification in S1, with a = req_adr, p = req_part:
  - req_risc=1: type=3, bank=0, offset=0, err=0.
  - a < arrStart[p]: type=0, bank=(a>>2) mod NB_SCALAR, offset=((a>>2)/NB_SCALAR)<<2. NB_SCALAR must be a power of 2, checked by elaboration assertion.
  - a < cycStart[p]: type=1, base=arrStart, shift=arrShift.
  - else: type=2, base=cycStart, shift=cycShift.
- Bank and offset for array/cyclic in S2:
  - bank = (a-base)>>shift.
  - offset = (a-base) & ((1<<shift)-1).
- Error in S2:
  - err=1 if shift-valid=0, or bank ≥ NB of that type, or limit[p]≠0 && a ≥ limit[p].
  - On err, rsp_bank is forced to 0, rsp_type is retained, and the result is still delivered (no drop).
- Widths:
  - Subtraction is AW-bit unsigned.
  - The bank index is truncated to BIW only after the range check.
- Reset mid-operation: all in-flight results are discarded; nothing is emitted after rstn rises until new requests arrive.

Decomposition:
- xmem_param_pkg gains:
  - mem_type_e (SCALAR/ARRAY/CYCLIC/NONE).
  - cfg_field_e.
  - BIW.
  - the xmem_route_rsp_t struct (type, bank, offset, err).
- Sub-module xmem_bank_route_ch: one channel's S1/S2 pipeline and decode, instantiated NUM_CH times.
- The top holds the shared config register file and the cfg_ready drain logic.

Test Plan:
- Config p0: arrStart=0x100, cycStart=0x300, arrSize=0x40, cycSize=0x20, NB=4/8/8. Request 0x0C on ch0 -> 2 cycles later type=0, bank=3, offset=0.
- Same config, 0x1C4 -> type=1, bank=3, offset=4. 0x344 -> type=2, bank=2, offset=4. 0x400 -> type=2, err=1 (bank 8 ≥ 8), rsp_bank=0.
- Backpressure: hold rsp_ready=0 for 5 cycles with back-to-back requests -> req_ready drops after 2 accepted, outputs stable, no loss or reorder after release.
- Config while busy: cfg_we asserted with 2 requests in flight -> cfg_ready=0 until drain. The new arrSize=0x80 is applied only to requests accepted afterwards.
- arrSize=0 then array request -> err=1. req_risc=1 -> type=3, err=0.
- rstn asserted with both channels full -> rsp_valid=0 immediately. No stale responses after release.
